// File: rtl/tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// tx_ctrl_pkg : state encoding, training pattern and code reset values
// Rev 1.0
// ============================================================================
package tx_ctrl_pkg;

    typedef logic [2:0] lane_state_t;

    localparam lane_state_t ST_OFF     = 3'd0;
    localparam lane_state_t ST_SETTLE  = 3'd1;
    localparam lane_state_t ST_TRAIN   = 3'd2;
    localparam lane_state_t ST_ACTIVE  = 3'd3;
    localparam lane_state_t ST_QUIESCE = 3'd4;

    localparam int DEF_SER_W = 4;
    localparam int DEF_DL_W  = 4;
    localparam int DEF_DRV_W = 4;

    localparam int MAX_CODE_W = 64;

    localparam logic [MAX_CODE_W-1:0] DL_RST_VAL  = '0;
    localparam logic [MAX_CODE_W-1:0] PU_RST_VAL  = '0;
    localparam logic [MAX_CODE_W-1:0] PDB_RST_VAL = '1;

    // Alternating pattern with bit 0 low, so the serializer emits 0,1,0,1...
    function automatic logic [MAX_CODE_W-1:0] train_pattern(input int w);
        logic [MAX_CODE_W-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_CODE_W; i++) begin
            if (i < w) p[i] = (i % 2) == 1;
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cyc_timer.sv
`default_nettype none
// ============================================================================
// cyc_timer : loadable down-counter that holds at 1; done while at 1
// Rev 1.0
// ============================================================================
module cyc_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rstb_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/tx_lane_ctrl.sv
`default_nettype none
// ============================================================================
// tx_lane_ctrl : per-lane TX bring-up / retune sequencer and word feeder
// Rev 1.0
// ============================================================================
module tx_lane_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int SER_W      = DEF_SER_W,
  parameter int DL_W       = DEF_DL_W,
  parameter int DRV_W      = DEF_DRV_W,
  parameter int SETTLE_CYC = 8,
  parameter int TRAIN_CYC  = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DL_W-1:0]  cfg_dl,
  input  logic [DRV_W-1:0] cfg_pu,
  input  logic [DRV_W-1:0] cfg_pdb,
  input  logic             train_req,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [SER_W-1:0] tx_data,
  output logic [SER_W-1:0] din,
  output logic [DL_W-1:0]  dl_ctrl,
  output logic [DRV_W-1:0] pu_ctl,
  output logic [DRV_W-1:0] pd_ctlb,
  output logic             driver_en,
  output logic             driver_enb,
  output logic [2:0]       state,
  output logic             link_up
);

  localparam int C_MAX_CYC = (SETTLE_CYC > TRAIN_CYC) ? SETTLE_CYC : TRAIN_CYC;
  localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);

  localparam logic [C_CNT_W-1:0] c_settle_ld = C_CNT_W'(SETTLE_CYC);
  localparam logic [C_CNT_W-1:0] c_train_ld  = C_CNT_W'(TRAIN_CYC);
  localparam logic [SER_W-1:0]   c_train_pat = SER_W'(train_pattern(SER_W));
  localparam logic [DL_W-1:0]    c_dl_rst    = DL_W'(DL_RST_VAL);
  localparam logic [DRV_W-1:0]   c_pu_rst    = DRV_W'(PU_RST_VAL);
  localparam logic [DRV_W-1:0]   c_pdb_rst   = DRV_W'(PDB_RST_VAL);

  lane_state_t      state_q,  state_d;
  logic [SER_W-1:0] din_q,    din_d;
  logic [DL_W-1:0]  dl_q,     dl_d;
  logic [DRV_W-1:0] pu_q,     pu_d;
  logic [DRV_W-1:0] pdb_q,    pdb_d;
  logic [DL_W-1:0]  sh_dl_q,  sh_dl_d;
  logic [DRV_W-1:0] sh_pu_q,  sh_pu_d;
  logic [DRV_W-1:0] sh_pdb_q, sh_pdb_d;
  logic             drv_en_q, drv_en_d;

  logic               w_cfg_hs;
  logic               w_tx_hs;
  logic               w_tmr_load;
  logic [C_CNT_W-1:0] w_tmr_val;
  logic               w_tmr_done;

  assign tx_ready  = (state_q == ST_ACTIVE) && en;
  assign cfg_ready = (state_q == ST_OFF) || ((state_q == ST_ACTIVE) && en);
  assign w_cfg_hs  = cfg_valid && cfg_ready;
  assign w_tx_hs   = tx_valid && tx_ready;

  cyc_timer #(
    .CNT_W (C_CNT_W)
  ) u_timer (
    .clk_i      (clk),
    .rstb_i     (rstb),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .done_o     (w_tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    dl_d       = dl_q;
    pu_d       = pu_q;
    pdb_d      = pdb_q;
    sh_dl_d    = sh_dl_q;
    sh_pu_d    = sh_pu_q;
    sh_pdb_d   = sh_pdb_q;
    w_tmr_load = 1'b0;
    w_tmr_val  = c_settle_ld;

    // Codes may change directly only while the driver is off.
    if (w_cfg_hs && (state_q == ST_OFF)) begin
      dl_d  = cfg_dl;
      pu_d  = cfg_pu;
      pdb_d = cfg_pdb;
    end

    if (!en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d    = ST_SETTLE;
          w_tmr_load = 1'b1;
          w_tmr_val  = c_settle_ld;
        end
        ST_SETTLE: begin
          if (w_tmr_done) begin
            state_d    = ST_TRAIN;
            w_tmr_load = 1'b1;
            w_tmr_val  = c_train_ld;
          end
        end
        ST_TRAIN: begin
          if (w_tmr_done) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_cfg_hs) begin
            sh_dl_d    = cfg_dl;
            sh_pu_d    = cfg_pu;
            sh_pdb_d   = cfg_pdb;
            state_d    = ST_QUIESCE;
            w_tmr_load = 1'b1;
            w_tmr_val  = c_settle_ld;
          end else if (train_req) begin
            state_d    = ST_TRAIN;
            w_tmr_load = 1'b1;
            w_tmr_val  = c_train_ld;
          end
        end
        ST_QUIESCE: begin
          if (w_tmr_done) begin
            // New codes land on the same edge the driver switches off.
            dl_d       = sh_dl_q;
            pu_d       = sh_pu_q;
            pdb_d      = sh_pdb_q;
            state_d    = ST_SETTLE;
            w_tmr_load = 1'b1;
            w_tmr_val  = c_settle_ld;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_comb begin
    din_d    = '0;
    drv_en_d = 1'b0;
    case (state_d)
      ST_TRAIN: begin
        din_d    = c_train_pat;
        drv_en_d = 1'b1;
      end
      ST_ACTIVE: begin
        if (w_tx_hs) din_d = tx_data;
        drv_en_d = 1'b1;
      end
      ST_QUIESCE: drv_en_d = 1'b1;
      default: begin
        din_d    = '0;
        drv_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_OFF;
      din_q    <= '0;
      dl_q     <= c_dl_rst;
      pu_q     <= c_pu_rst;
      pdb_q    <= c_pdb_rst;
      sh_dl_q  <= c_dl_rst;
      sh_pu_q  <= c_pu_rst;
      sh_pdb_q <= c_pdb_rst;
      drv_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      dl_q     <= dl_d;
      pu_q     <= pu_d;
      pdb_q    <= pdb_d;
      sh_dl_q  <= sh_dl_d;
      sh_pu_q  <= sh_pu_d;
      sh_pdb_q <= sh_pdb_d;
      drv_en_q <= drv_en_d;
    end
  end

  assign din        = din_q;
  assign dl_ctrl    = dl_q;
  assign pu_ctl     = pu_q;
  assign pd_ctlb    = pdb_q;
  assign driver_en  = drv_en_q;
  assign driver_enb = ~drv_en_q;
  assign state      = state_q;
  assign link_up    = (state_q == ST_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_tx_lane_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tx_lane_ctrl : directed scenarios checked against a schedule-based model
// Rev 1.0
// ============================================================================
module tb_tx_lane_ctrl;

  localparam int SER_W = 4;
  localparam int DL_W  = 4;
  localparam int DRV_W = 4;
  localparam int SET   = 8;
  localparam int TR    = 16;

  localparam int K_OFF = 0, K_BRING = 1, K_RETRAIN = 2, K_QUIESCE = 3;
  localparam int S_OFF = 0, S_SETTLE = 1, S_TRAIN = 2, S_ACTIVE = 3, S_QUIESCE = 4;

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DL_W-1:0]  cfg_dl = '0;
  logic [DRV_W-1:0] cfg_pu = '0;
  logic [DRV_W-1:0] cfg_pdb = '1;
  logic             train_req = 1'b0;
  logic             tx_valid = 1'b0;
  logic [SER_W-1:0] tx_data = '0;
  logic             cfg_ready, tx_ready, driver_en, driver_enb, link_up;
  logic [SER_W-1:0] din;
  logic [DL_W-1:0]  dl_ctrl;
  logic [DRV_W-1:0] pu_ctl, pd_ctlb;
  logic [2:0]       state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  tx_lane_ctrl #(
    .SER_W(SER_W), .DL_W(DL_W), .DRV_W(DRV_W), .SETTLE_CYC(SET), .TRAIN_CYC(TR)
  ) dut (
    .clk(clk), .rstb(rstb), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_dl(cfg_dl), .cfg_pu(cfg_pu), .cfg_pdb(cfg_pdb),
    .train_req(train_req),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .din(din), .dl_ctrl(dl_ctrl), .pu_ctl(pu_ctl), .pd_ctlb(pd_ctlb),
    .driver_en(driver_en), .driver_enb(driver_enb),
    .state(state), .link_up(link_up)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // State as a function of sequence kind and cycles since the starting edge.
  function automatic int phase(input int kind, input int d);
    case (kind)
      K_BRING:   return (d <= SET) ? S_SETTLE : (d <= SET + TR) ? S_TRAIN : S_ACTIVE;
      K_RETRAIN: return (d <= TR) ? S_TRAIN : S_ACTIVE;
      K_QUIESCE: return (d <= SET) ? S_QUIESCE : (d <= 2 * SET) ? S_SETTLE :
                        (d <= 2 * SET + TR) ? S_TRAIN : S_ACTIVE;
      default:   return S_OFF;
    endcase
  endfunction

  function automatic logic [SER_W-1:0] alt_pattern();
    logic [SER_W-1:0] p;
    for (int i = 0; i < SER_W; i++) p[i] = (i % 2) == 1;
    return p;
  endfunction

  int               m_kind = K_OFF, m_start = 0, ecnt = 0;
  int               e_state = S_OFF;
  logic [SER_W-1:0] e_din = '0;
  logic [DL_W-1:0]  e_dl = '0, p_dl = '0;
  logic [DRV_W-1:0] e_pu = '0, e_pdb = '1, p_pu = '0, p_pdb = '1;
  bit               m_applied = 1'b1;

  initial begin : model
    int cur;
    bit was_tx;
    forever begin
      @(posedge clk);
      if (!rstb) begin
        m_kind = K_OFF; m_start = 0; ecnt = 0; e_state = S_OFF; e_din = '0;
        e_dl = '0; e_pu = '0; e_pdb = '1; m_applied = 1'b1;
      end else begin
        cur    = phase(m_kind, ecnt - m_start + 1);
        was_tx = (cur == S_ACTIVE) && en && tx_valid;
        ecnt   = ecnt + 1;
        if (cur == S_OFF && cfg_valid) begin
          e_dl = cfg_dl; e_pu = cfg_pu; e_pdb = cfg_pdb;
        end
        if (!en) begin
          m_kind = K_OFF;
        end else if (cur == S_OFF) begin
          m_kind = K_BRING; m_start = ecnt;
        end else if (cur == S_ACTIVE && cfg_valid) begin
          m_kind = K_QUIESCE; m_start = ecnt; m_applied = 1'b0;
          p_dl = cfg_dl; p_pu = cfg_pu; p_pdb = cfg_pdb;
        end else if (cur == S_ACTIVE && train_req) begin
          m_kind = K_RETRAIN; m_start = ecnt;
        end
        e_state = phase(m_kind, ecnt - m_start + 1);
        if (m_kind == K_QUIESCE && e_state == S_SETTLE && !m_applied) begin
          e_dl = p_dl; e_pu = p_pu; e_pdb = p_pdb; m_applied = 1'b1;
        end
        if (e_state == S_TRAIN)                 e_din = alt_pattern();
        else if (e_state == S_ACTIVE && was_tx) e_din = tx_data;
        else                                    e_din = '0;
      end
    end
  end

  initial begin : compare
    bit drv;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        drv = (e_state == S_TRAIN) || (e_state == S_ACTIVE) || (e_state == S_QUIESCE);
        chk("state", int'(state), e_state);
        chk("din", int'(din), int'(e_din));
        chk("dl_ctrl", int'(dl_ctrl), int'(e_dl));
        chk("pu_ctl", int'(pu_ctl), int'(e_pu));
        chk("pd_ctlb", int'(pd_ctlb), int'(e_pdb));
        chk("driver_en", int'(driver_en), int'(drv));
        chk("driver_enb", int'(driver_enb), int'(!drv));
        chk("link_up", int'(link_up), int'(e_state == S_ACTIVE));
        chk("tx_ready", int'(tx_ready), int'(e_state == S_ACTIVE && en));
        chk("cfg_ready", int'(cfg_ready), int'(e_state == S_OFF || (e_state == S_ACTIVE && en)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin : stim
    repeat (3) @(posedge clk);
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_dl", int'(dl_ctrl), 0);
    chk("rst_pu", int'(pu_ctl), 0);
    chk("rst_pdb", int'(pd_ctlb), 4'hF);
    chk("rst_drv", int'(driver_en), 0);
    chk("rst_drvb", int'(driver_enb), 1);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_tx_ready", int'(tx_ready), 0);
    rstb   = 1'b1;
    cmp_en = 1'b1;

    // Bring-up: en sampled at edge 0.
    en = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 8)  begin chk("bu_c8_drv", int'(driver_en), 0); chk("bu_c8_din", int'(din), 0); end
      if (c == 9)  begin chk("bu_c9_drv", int'(driver_en), 1); chk("bu_c9_din", int'(din), 4'b1010); end
      if (c == 24) chk("bu_c24_state", int'(state), 2);
      if (c == 25) begin chk("bu_c25_link", int'(link_up), 1); chk("bu_c25_txrdy", int'(tx_ready), 1); end
    end

    // Mission stream with an idle gap.
    tx_valid = 1'b1; tx_data = 4'h3; tick(); chk("stream_3", int'(din), 4'h3);
    tx_data = 4'hC;                  tick(); chk("stream_C", int'(din), 4'hC);
    tx_valid = 1'b0;                 tick(); chk("stream_idle", int'(din), 0);
    tx_valid = 1'b1; tx_data = 4'h5; tick(); chk("stream_5", int'(din), 4'h5);
    tx_valid = 1'b0;

    // Retune while active.
    cfg_valid = 1'b1; cfg_dl = 4'd5; cfg_pu = 4'd0; cfg_pdb = 4'hF;
    #1 chk("q_cfg_ready", int'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c > 1) tick();
      if (c == 1 || c == 8) begin
        chk("q_state", int'(state), 4); chk("q_txrdy", int'(tx_ready), 0);
        chk("q_din", int'(din), 0);     chk("q_dl_old", int'(dl_ctrl), 0);
      end
      if (c == 9)  begin chk("q_dl_new", int'(dl_ctrl), 5); chk("q_drv_off", int'(driver_en), 0); end
      if (c == 17) chk("q_train", int'(state), 2);
      if (c == 33) chk("q_active", int'(link_up), 1);
    end

    // Retrain with a second request mid-training that must be ignored.
    train_req = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      train_req = (c == 3);
      if (c == 16) chk("rt_c16_state", int'(state), 2);
      if (c == 17) chk("rt_c17_link", int'(link_up), 1);
    end

    // Drop enable in training cycle 5.
    train_req = 1'b1; tick(); train_req = 1'b0;
    repeat (4) tick();
    en = 1'b0; tick();
    chk("off_state", int'(state), 0);
    chk("off_drv", int'(driver_en), 0);
    chk("off_drvb", int'(driver_enb), 1);
    chk("off_din", int'(din), 0);
    chk("off_dl", int'(dl_ctrl), 5);

    // Configure while off.
    cfg_valid = 1'b1; cfg_pu = 4'd3; cfg_pdb = ~4'd3; tick(); cfg_valid = 1'b0;
    chk("offcfg_pu", int'(pu_ctl), 3);
    chk("offcfg_pdb", int'(pd_ctlb), 4'hC);
    chk("offcfg_drv", int'(driver_en), 0);

    // cfg beats train_req in ACTIVE.
    en = 1'b1; repeat (25) tick();
    chk("bu2_link", int'(link_up), 1);
    cfg_valid = 1'b1; train_req = 1'b1; cfg_dl = 4'd9;
    #1 chk("both_cfg_ready", int'(cfg_ready), 1);
    tick(); cfg_valid = 1'b0; train_req = 1'b0;
    chk("both_state", int'(state), 4);
    repeat (32) tick();
    chk("both_active", int'(state), 3);
    chk("both_dl", int'(dl_ctrl), 9);

    // en=0 beats cfg and train_req together.
    cfg_valid = 1'b1; train_req = 1'b1; cfg_dl = 4'd2; cfg_pu = 4'd7; en = 1'b0;
    #1 chk("en0_cfg_ready", int'(cfg_ready), 0);
    tick(); cfg_valid = 1'b0; train_req = 1'b0;
    chk("en0_state", int'(state), 0);
    chk("en0_dl", int'(dl_ctrl), 9);
    chk("en0_pu", int'(pu_ctl), 3);

    // Pending shadow is discarded when enable drops during quiesce.
    en = 1'b1; repeat (25) tick();
    cfg_valid = 1'b1; cfg_dl = 4'd2; tick(); cfg_valid = 1'b0;
    repeat (3) tick();
    en = 1'b0; tick();
    en = 1'b1; repeat (25) tick();
    chk("discard_link", int'(link_up), 1);
    chk("discard_dl", int'(dl_ctrl), 9);

    cmp_en = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
